logic_gate_unit: RTL and testbench
==================================

Name: logic_gate_unit

Overview:
- Parametrised, registered successor to the single-bit AND gate.
- WIDTH-bit bitwise logic unit with 8 selectable gate operations and a valid/ready handshake on input and output.
- Accumulate mode folds a multi-beat burst into one result.
- Used as the standard gate primitive under test in the basics benches, and as a reusable datapath element.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat offered
in_ready  output  1  unit can accept a beat
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A, 7 NOT_A
in_acc  input  1  beat starts an accumulate burst (sampled only in IDLE)
in_last  input  1  final beat of an accumulate burst
out_valid  output  1  result held in output register
out_ready  input  1  downstream accepts result
out_y  output  WIDTH  result
out_red  output  1  AND-reduction of out_y (all ones)

Behaviour:
- Clock, reset and ready:
  - Single clock domain.
  - Reset is synchronous and active-high on clk.
  - in_ready = !rst && (!out_valid || out_ready). This is combinational, so the unit accepts a new beat in the same cycle the old result leaves.
  - A beat transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Reset values:
  - out_valid=0, out_y=0, out_red=0 (out_red is derived from out_y).
  - state=IDLE, acc=0, latched op=0.
  - in_ready=0 while rst is high.
  - Reset mid-burst discards the partial accumulation.
- Function f(x,y,op):
  - Ops 0-5: bitwise gate.
  - PASS_A: x.
  - NOT_A: ~x.
  - All widths equal WIDTH. No carries or extension.
- State machine: IDLE, ACC.
  - IDLE, beat with in_acc=0: out_y <= f(in_a,in_b,in_op); out_valid <= 1 on the next edge (1-cycle latency). in_last is ignored.
  - IDLE, beat with in_acc=1, in_last=1: same result and latency as in_acc=0 (single-beat burst). Stay in IDLE.
  - IDLE, beat with in_acc=1, in_last=0: acc <= f(in_a,in_b,in_op); latch op; go to ACC. out_valid is unchanged.
  - ACC, beat with in_last=0: acc <= f(acc,in_b,latched_op). in_a, in_op and in_acc are ignored.
  - ACC, beat with in_last=1: out_y <= f(acc,in_b,latched_op); out_valid <= 1; go to IDLE.
  - PASS_A/NOT_A in ACC operate on acc, so NOT_A toggles acc each beat.
- Output register:
  - out_valid clears on an output transfer unless a new result loads in the same cycle, in which case it stays 1 with the new out_y.
  - out_y is stable while out_valid && !out_ready.
  - ACC beats that produce no result still obey the in_ready rule. A pending unaccepted result back-pressures the whole burst.
- Back-to-back throughput: one beat per cycle when out_ready is held high.

Optional Feature:
- Macro: LOGIC_GATE_UNIT_STATS_EN
- Defined:
  - Adds output port out_beats (16 bits): the number of input beats that formed the current out_y, including 1 for a non-accumulate beat.
  - Internal beat counter saturates at 16'hFFFF.
  - Counter clears on reset and whenever a burst starts in IDLE.
  - out_beats resets to 0 and updates together with out_y.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_y=8'h00, in_ready=0. After release, in_ready=1.
- All ops, WIDTH=8, a=8'hCA, b=8'hF0, in_acc=0, out_ready=1 -> next cycle out_y: AND C0, OR FA, XOR 3A, NAND 3F, NOR 05, XNOR C5, PASS_A CA, NOT_A 35. out_red=0 for all eight.
- Accumulate AND burst, out_ready=1, 3 beats:
  - Beats: (a=FF,b=F3,acc=1,last=0), (b=7F,last=0), (b=3E,last=1).
  - Required: exactly one out_valid pulse, 1 cycle after the last beat, out_y=8'h32, out_beats=3 when STATS_EN.
- Back-pressure: out_ready=0 after result 8'hC0 -> in_ready=0, out_y holds C0 for 5 cycles. Raise out_ready with a new beat OR(0F,F0) -> same-cycle handover, next out_y=8'hFF, out_red=1.
- Reset mid-burst: XOR burst started with a=8'h0F,b=8'h00, then rst for 1 cycle -> state IDLE. A following in_acc=0 AND(FF,81) -> out_y=8'h81, no residue of the burst.
- Throughput: 8 consecutive XOR beats, a=i, b=8'h55, out_ready=1 -> 8 results on 8 consecutive cycles, i^8'h55, no gaps.

Source files
------------

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered WIDTH-bit bitwise logic unit with valid/ready handshake and burst accumulate
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_ready = !rst && (!out_valid || out_ready)
//   in_a, in_b, in_op   operands and gate select (AND OR XOR NAND NOR XNOR PASS_A NOT_A)
//   in_acc, in_last     burst start (IDLE only) and burst end
//   out_valid/out_ready output handshake; out_y result, out_red = &out_y
//   LOGIC_GATE_UNIT_STATS_EN adds out_beats: number of input beats that formed out_y
module logic_gate_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_red
`ifdef LOGIC_GATE_UNIT_STATS_EN
  ,
  output logic [15:0]      out_beats
`endif
);
  typedef enum logic {IDLE, ACC} state_t;
  function automatic logic [WIDTH-1:0] f(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] op);
    return op == 3'd0 ? x & y :
           op == 3'd1 ? x | y :
           op == 3'd2 ? x ^ y :
           op == 3'd3 ? ~(x & y) :
           op == 3'd4 ? ~(x | y) :
           op == 3'd5 ? ~(x ^ y) :
           op == 3'd6 ? x : ~x;
  endfunction
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, y_q, y_d, r;
  logic [2:0] op_q, op_d;
  logic valid_q, valid_d, fire, load, start, in_acc_st;
  always_comb begin
    in_acc_st = state_q == ACC;
    in_ready = !rst && (!valid_q || out_ready);
    fire = in_valid && in_ready;
    r = f(in_acc_st ? acc_q : in_a, in_b, in_acc_st ? op_q : in_op);
    load = fire && (in_acc_st ? in_last : (!in_acc || in_last));
    start = fire && !in_acc_st && in_acc && !in_last;
    state_d = start ? ACC : load ? IDLE : state_q;
    acc_d = fire && !load ? r : acc_q;
    op_d = start ? in_op : op_q;
    y_d = load ? r : y_q;
    valid_d = load || (valid_q && !out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      op_q <= '0;
      y_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      op_q <= op_d;
      y_q <= y_d;
      valid_q <= valid_d;
    end
  end
  assign out_valid = valid_q;
  assign out_y = y_q;
  assign out_red = &y_q;
`ifdef LOGIC_GATE_UNIT_STATS_EN
  logic [15:0] cnt_q, cnt_d, beats_q, beats_d;
  always_comb begin
    cnt_d = !fire ? cnt_q : !in_acc_st ? 16'd1 : &cnt_q ? cnt_q : cnt_q + 16'd1;
    beats_d = load ? cnt_d : beats_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      beats_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      beats_q <= beats_d;
    end
  end
  assign out_beats = beats_q;
`endif
endmodule

// File: tb/tb_logic_gate_unit.sv
// tb_logic_gate_unit: scoreboard bench for logic_gate_unit with directed and randomized beats
module tb_logic_gate_unit;
  logic clk, rst, in_valid, in_ready, in_acc, in_last, out_valid, out_ready, out_red;
  logic [7:0] in_a, in_b, out_y;
  logic [2:0] in_op;
`ifdef LOGIC_GATE_UNIT_STATS_EN
  logic [15:0] out_beats;
`endif
  logic_gate_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_red(out_red)
`ifdef LOGIC_GATE_UNIT_STATS_EN
    , .out_beats(out_beats)
`endif
  );
  typedef struct { logic [7:0] y; int beats; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, pops = 0;
  bit rnd = 0, tp_on = 0;
  int tp_n = 0, tp_last = 0, tp_gap = 0;
  bit m_burst = 0;
  logic [7:0] m_acc;
  logic [2:0] m_op;
  int m_n;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [7:0] gate(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x;
      default: return ~x;
    endcase
  endfunction
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic acc, input logic last);
    exp_t e;
    if (!m_burst) begin
      if (acc && !last) begin
        m_burst = 1; m_acc = gate(a, b, op); m_op = op; m_n = 1;
      end else begin
        e.y = gate(a, b, op); e.beats = 1; sb.push_back(e);
      end
    end else begin
      m_n = m_n < 65535 ? m_n + 1 : m_n;
      if (last) begin
        e.y = gate(m_acc, b, m_op); e.beats = m_n; sb.push_back(e); m_burst = 0;
      end else m_acc = gate(m_acc, b, m_op);
    end
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic acc, input logic last);
    int n = 0;
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (++n > 100) begin
        chk("in_ready timeout", 0, 1);
        in_valid = 0;
        return;
      end
    end
    model(a, b, op, acc, last);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain empty", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      pops++;
      if (tp_on) begin
        if (tp_n > 0 && cyc != tp_last + 1) tp_gap++;
        tp_n++;
        tp_last = cyc;
      end
      if (sb.size() == 0) chk("unexpected output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_y", out_y, e.y);
        chk("out_red", out_red, &e.y);
`ifdef LOGIC_GATE_UNIT_STATS_EN
        chk("out_beats", out_beats, e.beats);
`endif
      end
    end
  end
  initial begin
    logic [7:0] tbl [8];
    int p0;
    tbl = '{8'hC0, 8'hFA, 8'h3A, 8'h3F, 8'h05, 8'hC5, 8'hCA, 8'h35};
    rst = 1; in_valid = 1; in_a = 8'hFF; in_b = 8'hFF; in_op = 0; in_acc = 0; in_last = 0; out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_y", out_y, 0);
      chk("rst in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      send(8'hCA, 8'hF0, 3'(i), 0, 0);
      @(negedge clk);
      chk("op table y", out_y, tbl[i]);
      chk("op table red", out_red, 0);
      @(posedge clk); #1;
    end
    drain();
    p0 = pops;
    send(8'hFF, 8'hF3, 0, 1, 0);
    @(negedge clk);
    chk("acc no early result", out_valid, 0);
    @(posedge clk); #1;
    send(8'h00, 8'h7F, 5, 0, 0);
    send(8'h00, 8'h3E, 7, 1, 1);
    @(negedge clk);
    chk("acc result valid", out_valid, 1);
    chk("acc result y", out_y, 8'h32);
`ifdef LOGIC_GATE_UNIT_STATS_EN
    chk("acc beats", out_beats, 3);
`endif
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("acc single pulse", pops - p0, 1);
    drain();
    out_ready = 0;
    send(8'hCA, 8'hF0, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp in_ready", in_ready, 0);
      chk("bp out_valid", out_valid, 1);
      chk("bp out_y hold", out_y, 8'hC0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(8'h0F, 8'hF0, 1, 0, 0);
    @(negedge clk);
    chk("handover y", out_y, 8'hFF);
    chk("handover red", out_red, 1);
    @(posedge clk); #1;
    drain();
    send(8'h0F, 8'h00, 2, 1, 0);
    rst = 1; m_burst = 0;
    @(posedge clk); #1;
    rst = 0;
    send(8'hFF, 8'h81, 0, 0, 0);
    @(negedge clk);
    chk("post-reset y", out_y, 8'h81);
    @(posedge clk); #1;
    drain();
    tp_on = 1; tp_n = 0; tp_gap = 0;
    for (int i = 0; i < 8; i++) send(8'(i), 8'h55, 2, 0, 0);
    drain();
    @(posedge clk); #1;
    tp_on = 0;
    chk("throughput count", tp_n, 8);
    chk("throughput gaps", tp_gap, 0);
    rnd = 1;
    for (int i = 0; i < 300; i++)
      send(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    rnd = 0;
    if (m_burst) send(8'h00, 8'($urandom), 0, 0, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
